calcula_pontuacao: RTL and testbench

- Score calculator that sits directly upstream of the board memory controller, as its score-read client.
- On request, it scans the first NUM_ROWS rows of player 1's board, then player 2's, through the controller's read path.
- Counts hit cells per player, then publishes both scores and a winner flag.
- Read-only: never asserts a write enable toward the controller.

---
 rtl/calcula_pontuacao.sv | 141 ++++++++++++++
 tb/tb_calcula_pontuacao.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/calcula_pontuacao.sv
// calcula_pontuacao: scans both players' boards through the memory controller and publishes hit scores and winner.
// Optional miss counters (erros_p1/erros_p2) are built when PONTUACAO_MISS_COUNT_EN is defined.
module calcula_pontuacao #(
  parameter int         NUM_ROWS     = 12,
  parameter int         READ_LATENCY = 2,
  parameter logic [3:0] HIT_CODE     = 4'h2,
  parameter logic [7:0] WIN_HITS     = 8'd20
) (
  input  logic        clk,
  input  logic        resetGeral,
  input  logic        start,
  input  logic        mem_grant,
  input  logic [63:0] data_in,
  output logic        readyCalculaPontuacao,
  output logic [4:0]  pontuacao_readaddr,
  output logic        jogadorPontuacao,
  output logic        busy,
  output logic        score_valid,
  output logic [7:0]  pontos_p1,
  output logic [7:0]  pontos_p2,
`ifdef PONTUACAO_MISS_COUNT_EN
  output logic [7:0]  erros_p1,
  output logic [7:0]  erros_p2,
`endif
  output logic        fim_jogo,
  output logic        vencedor
);
  localparam logic [4:0] LAST_ROW = 5'(NUM_ROWS - 1);
  localparam logic [7:0] LAST_DRN = 8'(READ_LATENCY - 1);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_READ, S_DRAIN, S_DONE} state_t;
  state_t                  r_state;
  logic [7:0]              r_drain;
  logic [READ_LATENCY-1:0] r_vld;
  logic [7:0]              r_hit_acc, r_hit_p1;
  logic                    w_begin, w_issue, w_abort, w_last, w_row_vld, w_fim;
  logic [7:0]              w_hit_nxt;
  function automatic logic [4:0] count_code(input logic [63:0] row, input logic [3:0] code);
    logic [4:0] n;
    n = '0;
    for (int k = 0; k < 16; k++) n = n + {4'b0, row[4*k +: 4] == code};
    return n;
  endfunction
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {4'b0, b};
    return s[8] ? 8'hff : s[7:0];
  endfunction
  always_comb begin
    w_begin   = r_state == S_IDLE && start;
    w_issue   = r_state == S_READ && mem_grant;
    w_abort   = (r_state == S_READ || r_state == S_DRAIN) && !mem_grant;
    w_last    = r_state == S_DRAIN && mem_grant && r_drain == LAST_DRN;
    w_row_vld = r_vld[READ_LATENCY-1];
    w_hit_nxt = sat_add(r_hit_acc, w_row_vld ? count_code(data_in, HIT_CODE) : 5'd0);
    w_fim     = r_hit_p1 >= WIN_HITS || w_hit_nxt >= WIN_HITS;
  end
  always_ff @(posedge clk or negedge resetGeral)
    if (!resetGeral) begin
      r_state               <= S_IDLE;
      r_drain               <= '0;
      readyCalculaPontuacao <= 1'b0;
      pontuacao_readaddr    <= '0;
      jogadorPontuacao      <= 1'b0;
      busy                  <= 1'b0;
      score_valid           <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_state               <= S_REQ;
          readyCalculaPontuacao <= 1'b1;
          pontuacao_readaddr    <= '0;
          jogadorPontuacao      <= 1'b0;
          busy                  <= 1'b1;
        end
        S_REQ: if (mem_grant) r_state <= S_READ;
        S_READ: if (mem_grant && pontuacao_readaddr == LAST_ROW) begin
          r_state               <= S_DRAIN;
          readyCalculaPontuacao <= 1'b0;
          r_drain               <= '0;
        end else if (mem_grant) pontuacao_readaddr <= pontuacao_readaddr + 5'd1;
        S_DRAIN: if (mem_grant && !w_last) r_drain <= r_drain + 8'd1;
        else if (w_last && !jogadorPontuacao) begin
          r_state               <= S_REQ;
          readyCalculaPontuacao <= 1'b1;
          pontuacao_readaddr    <= '0;
          jogadorPontuacao      <= 1'b1;
        end else if (w_last) begin
          r_state     <= S_DONE;
          busy        <= 1'b0;
          score_valid <= 1'b1;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // losing the grant restarts the current player's board from row 0
      if (w_abort) begin
        r_state               <= S_REQ;
        readyCalculaPontuacao <= 1'b1;
        pontuacao_readaddr    <= '0;
      end
    end
  always_ff @(posedge clk or negedge resetGeral)
    if (!resetGeral) begin
      r_vld     <= '0;
      r_hit_acc <= '0;
      r_hit_p1  <= '0;
      pontos_p1 <= '0;
      pontos_p2 <= '0;
      fim_jogo  <= 1'b0;
      vencedor  <= 1'b0;
    end else begin
      r_vld     <= w_abort ? '0 : READ_LATENCY'({r_vld, w_issue});
      r_hit_acc <= (w_begin || w_abort || w_last) ? '0 : w_hit_nxt;
      if (w_last && !jogadorPontuacao) r_hit_p1 <= w_hit_nxt;
      if (w_last && jogadorPontuacao) begin
        pontos_p1 <= r_hit_p1;
        pontos_p2 <= w_hit_nxt;
        fim_jogo  <= w_fim;
        vencedor  <= w_fim && r_hit_p1 > w_hit_nxt;
      end
    end
`ifdef PONTUACAO_MISS_COUNT_EN
  logic [7:0] r_mis_acc, r_mis_p1, w_mis_nxt;
  always_comb w_mis_nxt = sat_add(r_mis_acc, w_row_vld ? count_code(data_in, 4'h3) : 5'd0);
  always_ff @(posedge clk or negedge resetGeral)
    if (!resetGeral) begin
      r_mis_acc <= '0;
      r_mis_p1  <= '0;
      erros_p1  <= '0;
      erros_p2  <= '0;
    end else begin
      r_mis_acc <= (w_begin || w_abort || w_last) ? '0 : w_mis_nxt;
      if (w_last && !jogadorPontuacao) r_mis_p1 <= w_mis_nxt;
      if (w_last && jogadorPontuacao) begin
        erros_p1 <= r_mis_p1;
        erros_p2 <= w_mis_nxt;
      end
    end
`endif
endmodule

// File: tb/tb_calcula_pontuacao.sv
// tb_calcula_pontuacao: vector table, random boards with random grant loss, and corner sequences.
module tb_calcula_pontuacao;
  localparam int NR = 12, RL = 2, WIN = 20;
  logic        clk = 0, resetGeral = 1, start = 0, mem_grant = 1;
  logic [63:0] data_in;
  logic        ready, jog, busy, score_valid, fim_jogo, vencedor;
  logic [4:0]  addr;
  logic [7:0]  pontos_p1, pontos_p2;
`ifdef PONTUACAO_MISS_COUNT_EN
  logic [7:0]  erros_p1, erros_p2;
`endif
  logic [63:0] mem [2][32];
  logic [5:0]  pipe [RL];
  int n_vec = 0, n_err = 0;
  calcula_pontuacao dut (
    .clk(clk), .resetGeral(resetGeral), .start(start), .mem_grant(mem_grant), .data_in(data_in),
    .readyCalculaPontuacao(ready), .pontuacao_readaddr(addr), .jogadorPontuacao(jog), .busy(busy),
    .score_valid(score_valid), .pontos_p1(pontos_p1), .pontos_p2(pontos_p2),
`ifdef PONTUACAO_MISS_COUNT_EN
    .erros_p1(erros_p1), .erros_p2(erros_p2),
`endif
    .fim_jogo(fim_jogo), .vencedor(vencedor));
  always #5 clk = ~clk;
  // controller model: row data appears RL cycles after its address
  always @(posedge clk) begin
    pipe[0] <= {jog, addr};
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign data_in = mem[pipe[RL-1][5]][pipe[RL-1][4:0]];
  typedef struct {
    logic [63:0] r1, r2;
    logic [7:0]  e1, e2;
    logic        ef, ev;
  } vec_t;
  vec_t vt [8];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] ref_score(input int p, input logic [3:0] code);
    int s = 0;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < 16; k++) if (mem[p][r][4*k +: 4] == code) s++;
    return s > 255 ? 8'hff : 8'(s);
  endfunction
  function automatic logic ref_venc(input int a, input int b);
    if (a >= WIN && b >= WIN) return a > b;
    return a >= WIN;
  endfunction
  task automatic fill(input logic [63:0] a, input logic [63:0] b);
    for (int r = 0; r < 32; r++) begin
      mem[0][r] = a;
      mem[1][r] = b;
    end
  endtask
  task automatic fill_rand();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 32; r++)
        for (int k = 0; k < 16; k++) mem[p][r][4*k +: 4] = 4'($urandom_range(0, 3));
  endtask
  task automatic run_scan(input bit rg, output int cyc, output bit ok, output bit b1);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    cyc = 1;
    b1 = busy;
    while (!score_valid && cyc < 3000) begin
      if (rg) mem_grant = $urandom_range(0, 9) != 0;
      @(negedge clk);
      cyc++;
    end
    mem_grant = 1;
    ok = score_valid;
  endtask
  task automatic check_out(input string nm, input logic [7:0] e1, input logic [7:0] e2, input logic ef, input logic ev);
    chk({nm, "_p1"}, pontos_p1, e1);
    chk({nm, "_p2"}, pontos_p2, e2);
    chk({nm, "_fim"}, fim_jogo, ef);
    chk({nm, "_venc"}, vencedor, ev);
`ifdef PONTUACAO_MISS_COUNT_EN
    chk({nm, "_miss1"}, erros_p1, ref_score(0, 4'h3));
    chk({nm, "_miss2"}, erros_p2, ref_score(1, 4'h3));
`endif
  endtask
  initial begin
    int cyc, pulses;
    bit ok, b1;
    logic [7:0] e1, e2;
    vt[0] = '{64'h0000_0000_0000_0022, 64'h0, 8'd24, 8'd0, 1'b1, 1'b1};
    vt[1] = '{64'h2222_2222_2222_2222, 64'h2222_2222_2222_2222, 8'd192, 8'd192, 1'b1, 1'b0};
    vt[2] = '{64'h0, 64'h0, 8'd0, 8'd0, 1'b0, 1'b0};
    vt[3] = '{64'h0000_0000_0000_0002, 64'h0000_0000_0200_0000, 8'd12, 8'd12, 1'b0, 1'b0};
    vt[4] = '{64'h0, 64'h2222_2222_2222_2222, 8'd0, 8'd192, 1'b1, 1'b0};
    vt[5] = '{64'h3333_3333_3333_3333, 64'h0000_0000_0000_0222, 8'd0, 8'd36, 1'b1, 1'b0};
    vt[6] = '{64'h2222_0000_0000_0000, 64'h2222_2000_0000_0000, 8'd48, 8'd60, 1'b1, 1'b0};
    vt[7] = '{64'h2222_2000_0000_0000, 64'h2222_0000_0000_0000, 8'd60, 8'd48, 1'b1, 1'b1};
    fill(64'h0, 64'h0);
    #2 resetGeral = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", {ready, addr, jog, busy, score_valid, pontos_p1, pontos_p2, fim_jogo, vencedor}, 0);
    resetGeral = 1;
    for (int i = 0; i < 8; i++) begin
      fill(vt[i].r1, vt[i].r2);
      run_scan(0, cyc, ok, b1);
      chk($sformatf("vec%0d_valid", i), ok, 1);
      chk($sformatf("vec%0d_cycles", i), cyc, 31);
      if (i == 0) chk("busy_after_start", b1, 1);
      check_out($sformatf("vec%0d", i), vt[i].e1, vt[i].e2, vt[i].ef, vt[i].ev);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i), score_valid, 0);
    end
    // exactly at the WIN_HITS threshold versus one below
    fill(64'h0, 64'h0);
    for (int r = 0; r < 10; r++) mem[1][r] = 64'h22;
    for (int r = 0; r < 9; r++) mem[0][r] = 64'h22;
    mem[0][9] = 64'h2;
    run_scan(0, cyc, ok, b1);
    chk("thr_valid", ok, 1);
    check_out("thr", 8'd19, 8'd20, 1'b1, 1'b0);
    for (int r = 0; r < 32; r++) {mem[0][r], mem[1][r]} = {mem[1][r], mem[0][r]};
    run_scan(0, cyc, ok, b1);
    check_out("thr_swap", 8'd20, 8'd19, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      fill_rand();
      e1 = ref_score(0, 4'h2);
      e2 = ref_score(1, 4'h2);
      run_scan(1, cyc, ok, b1);
      chk($sformatf("rnd%0d_valid", i), ok, 1);
      check_out($sformatf("rnd%0d", i), e1, e2, e1 >= WIN || e2 >= WIN, (e1 >= WIN || e2 >= WIN) && ref_venc(e1, e2));
    end
    fill_rand();
    e1 = ref_score(0, 4'h2);
    e2 = ref_score(1, 4'h2);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    cyc = 0;
    while (!(ready && jog && addr == 5) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("drop_reach_addr5", cyc < 200, 1);
    mem_grant = 0;
    @(negedge clk);
    chk("drop_restart_addr", {ready, jog, addr}, {1'b1, 1'b1, 5'd0});
    repeat (2) @(negedge clk);
    mem_grant = 1;
    cyc = 0;
    while (!score_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("drop_valid", score_valid, 1);
    check_out("drop", e1, e2, e1 >= WIN || e2 >= WIN, (e1 >= WIN || e2 >= WIN) && ref_venc(e1, e2));
    fill(64'h22, 64'h22);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (5) @(negedge clk);
    resetGeral = 0;
    #1;
    chk("rst_mid_outputs", {ready, addr, jog, busy, score_valid, pontos_p1, pontos_p2, fim_jogo, vencedor}, 0);
    @(negedge clk) resetGeral = 1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      pulses += int'(score_valid);
    end
    chk("rst_mid_no_valid", pulses, 0);
    chk("rst_mid_idle", {busy, ready}, 0);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      if (c == 5 || c == 20) start = 1;
      @(negedge clk);
      start = 0;
      pulses += int'(score_valid);
    end
    chk("busy_start_pulses", pulses, 1);
    check_out("after_rst", 8'd24, 8'd24, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
